// File: rtl/wb_sched.sv
// Register-file write scheduler: merges pipeline writes with long-latency results through a 2-entry buffer.
// Latency 1 to the write port; lu_ready drops when the buffer is full, pipeline writes always win.
module wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_waddr,
    output logic        iss_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        busy1,
    output logic        busy2,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         buf_q [2];
    logic [1:0]  count;
    logic [31:0] pending;

    logic        pipe_win, lu_acc, lu_keep, pop, push, bypass, iss_set;
    logic        win_vld, win_lu;
    wr_t         win, lu_ent;
    logic [31:0] pending_nxt;

    assign lu_ready  = !rst && (count < 2'd2);
    assign iss_ready = !rst && !pending[iss_waddr];
    assign busy1     = !rst && pending[raddr1] && (raddr1 != 5'd0);
    assign busy2     = !rst && pending[raddr2] && (raddr2 != 5'd0);

    always_comb begin
        lu_ent   = '{addr: lu_waddr, data: lu_wdata};
        pipe_win = pipe_we && (pipe_waddr != 5'd0);
        lu_acc   = lu_valid && lu_ready;
        lu_keep  = lu_acc && (lu_waddr != 5'd0);
        pop      = !pipe_win && (count != 2'd0);
        bypass   = !pipe_win && (count == 2'd0) && lu_keep;
        push     = lu_keep && !bypass;
        iss_set  = iss_valid && iss_ready && (iss_waddr != 5'd0);

        win_vld = 1'b0;
        win_lu  = 1'b0;
        win     = '0;
        if (pipe_win) begin
            win_vld = 1'b1;
            win     = '{addr: pipe_waddr, data: pipe_wdata};
        end else if (pop) begin
            win_vld = 1'b1;
            win_lu  = 1'b1;
            win     = buf_q[0];
        end else if (bypass) begin
            win_vld = 1'b1;
            win_lu  = 1'b1;
            win     = lu_ent;
        end

        // A reservation made in the same cycle as a clear must survive.
        pending_nxt = pending;
        if (win_lu)
            pending_nxt[win.addr] = 1'b0;
        if (iss_set)
            pending_nxt[iss_waddr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            pending <= '0;
            we      <= 1'b0;
            waddr   <= 5'd0;
            wdata   <= 32'd0;
        end else begin
            count   <= count + {1'b0, push} - {1'b0, pop};
            pending <= pending_nxt;
            we      <= win_vld;
            if (win_vld) begin
                waddr <= win.addr;
                wdata <= win.data;
            end
        end
    end

    // Buffer payload needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pop) begin
                buf_q[0] <= (push && count == 2'd1) ? lu_ent : buf_q[1];
            end else if (push) begin
                buf_q[count[0]] <= lu_ent;
            end
        end
    end
endmodule

// File: tb/tb_wb_sched.sv
// Directed vector table plus randomized run against a queue-based reference model of wb_sched.
module tb_wb_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        iss_ready;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [4:0]  raddr1, raddr2;
    logic        busy1, busy2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    wb_sched dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iv;
        logic [4:0]  ia;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_lr, e_ir, e_b1;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    bit          m_pend [32];
    ent_t        m_q[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic pwe_i, input logic [4:0] pa_i, input logic [31:0] pd_i,
                       input logic iv_i, input logic [4:0] ia_i, input logic lv_i, input logic [4:0] la_i,
                       input logic [31:0] ld_i, input logic [4:0] r1_i,
                       input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                       input logic elr, input logic eir, input logic eb1);
        vec_t v;
        v.rst = r; v.pwe = pwe_i; v.pa = pa_i; v.pd = pd_i; v.iv = iv_i; v.ia = ia_i;
        v.lv = lv_i; v.la = la_i; v.ld = ld_i; v.r1 = r1_i;
        v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_lr = elr; v.e_ir = eir; v.e_b1 = eb1;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_q.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
    endtask

    // Next state from the current inputs, applied as of the coming clock edge.
    task automatic model_step();
        bit   acc, bypassed, iss_ok;
        ent_t h;
        if (rst) begin
            model_reset();
            return;
        end
        acc      = lu_valid && (m_q.size() < 2);
        iss_ok   = iss_valid && !m_pend[iss_waddr];
        bypassed = 1'b0;
        if (pipe_we && pipe_waddr != 0) begin
            m_we = 1'b1; m_wa = pipe_waddr; m_wd = pipe_wdata;
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_we = 1'b1; m_wa = h.a; m_wd = h.d;
            m_pend[h.a] = 1'b0;
        end else if (acc && lu_waddr != 0) begin
            m_we = 1'b1; m_wa = lu_waddr; m_wd = lu_wdata;
            m_pend[lu_waddr] = 1'b0;
            bypassed = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (acc && lu_waddr != 0 && !bypassed)
            m_q.push_back('{a: lu_waddr, d: lu_wdata});
        if (iss_ok && iss_waddr != 0)
            m_pend[iss_waddr] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0; iss_valid = 0; iss_waddr = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0; raddr1 = 0; raddr2 = 0;

        //   rst pwe pa  pd       iv ia lv la  ld        r1 | we wa  wd        lr ir b1
        add(1, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 0,  0,        0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 0,  0,        1, 1, 0);
        add(0, 1, 5, 'h11,     0, 0, 0, 0,  0,        0,   0, 0,  0,        1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   1, 5,  'h11,     1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 5,  'h11,     1, 1, 0);
        add(0, 0, 0, 0,        1, 7, 0, 0,  0,        7,   0, 5,  'h11,     1, 1, 0);
        add(0, 0, 0, 0,        0, 7, 0, 0,  0,        7,   0, 5,  'h11,     1, 0, 1);
        add(0, 0, 0, 0,        0, 7, 0, 0,  0,        7,   0, 5,  'h11,     1, 0, 1);
        add(0, 0, 0, 0,        0, 0, 1, 7,  'hAB,     7,   0, 5,  'h11,     1, 1, 1);
        add(0, 0, 0, 0,        0, 7, 0, 0,  0,        7,   1, 7,  'hAB,     1, 1, 0);
        add(0, 1, 1, 'h100,    0, 0, 1, 8,  'h808,    0,   0, 7,  'hAB,     1, 1, 0);
        add(0, 1, 1, 'h101,    0, 0, 1, 9,  'h909,    0,   1, 1,  'h100,    1, 1, 0);
        add(0, 1, 1, 'h102,    0, 0, 1, 10, 'hA0A,    0,   1, 1,  'h101,    0, 1, 0);
        add(0, 1, 1, 'h103,    0, 0, 1, 10, 'hA0A,    0,   1, 1,  'h102,    0, 1, 0);
        add(0, 1, 1, 'h104,    0, 0, 1, 10, 'hA0A,    0,   1, 1,  'h103,    0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 1, 10, 'hA0A,    0,   1, 1,  'h104,    0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 1, 10, 'hA0A,    0,   1, 8,  'h808,    1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   1, 9,  'h909,    1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   1, 10, 'hA0A,    1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 10, 'hA0A,    1, 1, 0);
        add(0, 0, 0, 0,        1, 3, 0, 0,  0,        0,   0, 10, 'hA0A,    1, 1, 0);
        add(0, 0, 0, 0,        1, 3, 0, 0,  0,        3,   0, 10, 'hA0A,    1, 0, 1);
        add(0, 0, 0, 0,        0, 3, 1, 3,  'h33,     3,   0, 10, 'hA0A,    1, 0, 1);
        add(0, 0, 0, 0,        1, 3, 1, 3,  'h34,     3,   1, 3,  'h33,     1, 1, 0);
        add(0, 0, 0, 0,        0, 3, 0, 0,  0,        3,   1, 3,  'h34,     1, 0, 1);
        add(0, 0, 0, 0,        0, 0, 1, 3,  'h35,     3,   0, 3,  'h34,     1, 1, 1);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        3,   1, 3,  'h35,     1, 1, 0);
        add(0, 1, 2, 'h22,     0, 0, 1, 4,  'h44,     0,   0, 3,  'h35,     1, 1, 0);
        add(0, 1, 0, 'hDEAD,   0, 0, 0, 0,  0,        0,   1, 2,  'h22,     1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,  'h55,     0,   1, 4,  'h44,     1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 4,  'h44,     1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 4,  'h44,     1, 1, 0);
        add(0, 0, 0, 0,        1, 2, 0, 0,  0,        0,   0, 4,  'h44,     1, 1, 0);
        add(0, 0, 0, 0,        1, 6, 0, 0,  0,        2,   0, 4,  'h44,     1, 1, 1);
        add(0, 1, 1, 'h77,     0, 0, 1, 2,  'h222,    6,   0, 4,  'h44,     1, 1, 1);
        add(0, 1, 1, 'h78,     0, 0, 1, 6,  'h666,    6,   1, 1,  'h77,     1, 1, 1);
        add(1, 1, 1, 'h79,     0, 6, 0, 0,  0,        6,   1, 1,  'h78,     0, 0, 0);
        add(0, 0, 0, 0,        0, 6, 0, 0,  0,        6,   0, 0,  0,        1, 1, 0);
        add(0, 0, 0, 0,        0, 2, 0, 0,  0,        2,   0, 0,  0,        1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,  0,        0,   0, 0,  0,        1, 1, 0);

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; pipe_we = tbl[i].pwe; pipe_waddr = tbl[i].pa; pipe_wdata = tbl[i].pd;
            iss_valid = tbl[i].iv; iss_waddr = tbl[i].ia; lu_valid = tbl[i].lv; lu_waddr = tbl[i].la;
            lu_wdata = tbl[i].ld; raddr1 = tbl[i].r1; raddr2 = 0;
            @(negedge clk);
            chk($sformatf("row%0d we", i),        32'(we),        32'(tbl[i].e_we));
            chk($sformatf("row%0d waddr", i),     32'(waddr),     32'(tbl[i].e_wa));
            chk($sformatf("row%0d wdata", i),     wdata,          tbl[i].e_wd);
            chk($sformatf("row%0d lu_ready", i),  32'(lu_ready),  32'(tbl[i].e_lr));
            chk($sformatf("row%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_ir));
            chk($sformatf("row%0d busy1", i),     32'(busy1),     32'(tbl[i].e_b1));
            chk($sformatf("row%0d busy2", i),     32'(busy2),     32'd0);
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model, starting from a clean reset.
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(99) < 2);
            pipe_we    = ($urandom_range(99) < 45);
            pipe_waddr = 5'($urandom_range(7));
            pipe_wdata = $urandom;
            iss_valid  = ($urandom_range(99) < 30);
            iss_waddr  = 5'($urandom_range(7));
            lu_valid   = ($urandom_range(99) < 50);
            lu_waddr   = 5'($urandom_range(7));
            lu_wdata   = $urandom;
            raddr1     = 5'($urandom_range(7));
            raddr2     = 5'($urandom_range(7));
            @(negedge clk);
            chk("rnd we",        32'(we),        32'(m_we));
            if (m_we) begin
                chk("rnd waddr", 32'(waddr),     32'(m_wa));
                chk("rnd wdata", wdata,          m_wd);
            end
            chk("rnd lu_ready",  32'(lu_ready),  32'(!rst && m_q.size() < 2));
            chk("rnd iss_ready", 32'(iss_ready), 32'(!rst && !m_pend[iss_waddr]));
            chk("rnd busy1",     32'(busy1),     32'(!rst && m_pend[raddr1] && raddr1 != 0));
            chk("rnd busy2",     32'(busy2),     32'(!rst && m_pend[raddr2] && raddr2 != 0));
            model_step();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: pipe_we  input  1  single-cycle pipeline result valid this cycle.
REQ-004 SHALL: pipe_waddr / pipe_wdata  input  5 / 32  pipeline destination register and value.
REQ-005 SHALL: iss_valid / iss_waddr  input  1 / 5  long-latency op issued this cycle; reserves its destination.
REQ-006 SHALL: iss_ready  output  1  combinational; 1 when iss_waddr is not pending and rst=0.
REQ-007 SHALL: lu_valid / lu_waddr / lu_wdata  input  1 / 5 / 32  long-latency result offered.
REQ-008 SHALL: lu_ready  output  1  1 when result buffer count < 2 and rst=0; depends on registered count only.
REQ-009 SHALL: raddr1 / raddr2  input  5 / 5  decode-stage source registers for hazard query.
REQ-010 SHALL: busy1 / busy2  output  1 / 1  combinational; pending[raddrN] and raddrN != 0.
REQ-011 SHALL: we / waddr / wdata  output  1 / 5 / 32  registered write port to register file.

Function
REQ-012 SHALL: lu result accepted only on lu_valid && lu_ready; lu_valid while lu_ready=0 has no effect.
REQ-013 SHALL: write slot per cycle, priority: (1) pipe_we && pipe_waddr != 0; (2) buffer head; (3) accepted lu result when buffer empty (bypass); else idle.
REQ-014 SHALL: the winning write appears on we/waddr/wdata the next cycle (latency 1); idle cycle drives we=0, waddr/wdata hold previous values.
REQ-015 SHALL: pipe_we with pipe_waddr=0 is discarded and does not consume the slot.
REQ-016 SHALL: result buffer is 2-entry FIFO, order preserved; accepted lu result is pushed unless bypassed per REQ-013.
REQ-017 SHALL: push and pop in the same cycle leave count unchanged and both succeed.
REQ-018 SHALL: lu result with lu_waddr=0 is accepted and dropped (never written, never buffered).
REQ-019 SHALL: pending is a 32-bit mask; bit0 always 0.
REQ-020 SHALL: iss_valid && iss_ready && iss_waddr != 0 sets pending[iss_waddr] at the clock edge.
REQ-021 SHALL: pending[r] clears at the edge where an lu write to r is launched into the output register, so busy drops in the cycle the register file sees we for r.
REQ-022 SHALL: same-cycle set and clear of the same bit -> bit remains set.
REQ-023 SHALL: iss_valid with iss_ready=0 has no effect (no reservation).
REQ-024 SHALL: pipeline writes never modify pending.
REQ-025 SHALL: starvation is permitted; a continuous pipe_we stream blocks the buffer and lu_ready falls to 0 when full.

Reset
REQ-026 SHALL: while rst=1 at an edge: we=0, waddr=0, wdata=0, buffer count=0, pending=0.
REQ-027 SHALL: while rst=1: lu_ready=0, iss_ready=0, busy1=busy2=0; all inputs ignored.
REQ-028 SHALL: reset mid-operation discards buffered results and reservations with no write emitted afterwards.
REQ-029 SHALL: first cycle after rst deasserts: lu_ready=1, iss_ready=1.

Verification
REQ-030 SHALL: pipe_we=1, waddr=5, wdata=0x11 at cycle 0 -> cycle 1 we=1, waddr=5, wdata=0x11; cycle 2 we=0.
REQ-031 SHALL: iss r7 at c0; busy1=1 for raddr1=7 from c1; lu r7 data 0xAB at c3, no pipe -> c4 we=1 waddr=7 wdata=0xAB, busy1=0 in c4.
REQ-032 SHALL: pipe_we held 1 (r1) c0-c4 with lu results r8, r9, r10 offered from c0 -> r8, r9 accepted, lu_ready=0 from c2; after pipe_we drops, r8 then r9 written on consecutive cycles, then r10 accepted.
REQ-033 SHALL: r3 pending, iss_valid r3 -> iss_ready=0, no change; lu r3 write launched same cycle as new iss r3 -> pending[3] stays 1.
REQ-034 SHALL: pipe_waddr=0 with pipe_we=1 and buffered lu r4 -> r4 written next cycle; lu_waddr=0 result -> no write.
REQ-035 SHALL: rst pulsed with 2 buffered results and pending r2, r6 -> no subsequent we, busy=0, lu_ready=1 one cycle after release.
